// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine driving the HI/LO write port.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiplier; division stays iterative.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [1:0]  hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opd_q, opd_d;
  logic [63:0] acc_q, acc_d;
  logic        sgn, ge;
  logic [31:0] a_mag, b_mag;
  logic [32:0] msum, sh;
  logic [33:0] df;
  assign sgn   = ~op_i[0];
  assign a_mag = (sgn & a_i[31]) ? -a_i : a_i;
  assign b_mag = (sgn & b_i[31]) ? -b_i : b_i;
  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
  assign sh    = {acc_q[63:32], acc_q[31]};
  assign df    = {1'b0, sh} - {2'b0, opd_q};
  assign ge    = ~df[33];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (start_i) begin
        op_d    = op_i;
        sa_d    = sgn & a_i[31];
        sb_d    = sgn & b_i[31];
        cnt_d   = '0;
        opd_d   = op_i[1] ? b_mag : a_mag;
        acc_d   = {32'd0, op_i[1] ? a_mag : b_mag};
        state_d = ITER;
        if (op_i[1] && b_i == 32'd0) begin
          acc_d   = {a_i, 32'hFFFF_FFFF};
          state_d = DONE;
        end
`ifdef MULDIV_FAST_MULT_EN
        if (!op_i[1]) begin
          acc_d   = {{32{sgn & a_i[31]}}, a_i} * {{32{sgn & b_i[31]}}, b_i};
          state_d = DONE;
        end
`endif
      end
      ITER: begin
        acc_d   = op_q[1] ? {ge ? df[31:0] : sh[31:0], acc_q[30:0], ge} : {msum, acc_q[31:1]};
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'd31 ? FIX : ITER;
      end
      FIX: begin
        acc_d   = op_q[1] ? {sa_q ? -acc_q[63:32] : acc_q[63:32], (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0]}
                          : ((sa_q ^ sb_q) ? -acc_q : acc_q);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (cancel_i) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      opd_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
    end
  end
  assign busy_o    = state_q != IDLE;
  assign stall_o   = (state_q == IDLE && start_i && !cancel_i) || state_q == ITER || state_q == FIX;
  assign hilo_we_o = {2{state_q == DONE && !cancel_i}};
  assign hi_o      = state_q == DONE ? acc_q[63:32] : 32'd0;
  assign lo_o      = state_q == DONE ? acc_q[31:0] : 32'd0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit.
module tb_muldiv_unit;
  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, cancel_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy_o, stall_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] hi_o, lo_o;
  int checks = 0, errors = 0;
`ifdef MULDIV_FAST_MULT_EN
  localparam int ML = 1;
`else
  localparam int ML = 34;
`endif
  typedef struct {logic [31:0] hi; logic [31:0] lo; string tag;} exp_t;
  exp_t sb[$];
  exp_t e;
  muldiv_unit dut (.clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
                   .cancel_i(cancel_i), .busy_o(busy_o), .stall_o(stall_o), .hilo_we_o(hilo_we_o),
                   .hi_o(hi_o), .lo_o(lo_o));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (hilo_we_o !== 2'b00) begin
    if (sb.size() == 0) chk("unexpected_write", {62'd0, hilo_we_o}, 64'd0);
    else begin
      e = sb.pop_front();
      chk({e.tag, "_we"}, {62'd0, hilo_we_o}, 64'd3);
      chk({e.tag, "_hilo"}, {hi_o, lo_o}, {e.hi, e.lo});
    end
  end
  task automatic op_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input string tag, input bit hold = 1'b0);
    int n;
    sb.push_back('{eh, el, tag});
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    #1 chk({tag, "_stall_req"}, {63'd0, stall_o}, 64'd1);
    @(posedge clk);
    #1 if (hold) begin a_i = ~a; b_i = b + 32'd1; end else start_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n < lat) chk({tag, "_stall"}, {63'd0, stall_o}, 64'd1);
    end while (hilo_we_o === 2'b00 && n < 100);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_stall_done"}, {63'd0, stall_o}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_we_pulse"}, {62'd0, hilo_we_o}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy_o}, 64'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_we", {62'd0, hilo_we_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    op_i = 2'b11; a_i = 32'd9; b_i = 32'd2; start_i = 1'b1; cancel_i = 1'b1;
    #1 chk("cancel_start_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    chk("cancel_start_busy", {63'd0, busy_o}, 64'd0);
    start_i = 1'b0; cancel_i = 1'b0;
    op_run(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, ML, "mult_neg");
    op_run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, ML, "multu_max");
    op_run(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, ML, "mult_minmin");
    op_run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, "div_neg");
    op_run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, "div_negb");
    op_run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, "div_ovf");
    op_run(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, "divu_zero");
    op_run(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, "div_zero");
    op_run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, "divu");
    op_i = 2'b11; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) cancel_i = 1'b1;
    @(negedge clk) cancel_i = 1'b0;
    chk("cancel_busy", {63'd0, busy_o}, 64'd0);
    op_run(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, ML, "multu_after_cancel");
    op_run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, "divu_hold", 1'b1);
    repeat (5) @(negedge clk);
    chk("hold_idle", {63'd0, busy_o}, 64'd0);
    op_i = 2'b11; a_i = 32'hFFFF_FFFF; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    chk("midrst_stall", {63'd0, stall_o}, 64'd0);
    chk("midrst_we", {62'd0, hilo_we_o}, 64'd0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
